// File: rtl/hazard_pipe_tracker.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// hazard_pipe_tracker
//
// Producer-side companion to the EX-stage forwarding unit. Keeps a small
// record {valid, regwrite, dest, isLoad} for the instructions in EX, MEM and
// WB, and publishes the MEM/WB write-enable and write-register signals that
// the forwarding muxes consume. It also detects a load-use hazard between
// the load in EX and the instruction in ID. On a hazard it stalls ID for one
// cycle and inserts a bubble into EX. It also handles taken-branch flushes,
// a global memory-wait hold, and a saturating stall-cycle counter.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   id_valid         ID holds a real instruction
//   id_rs, id_rt     ID source register indices
//   id_rs_used/rt    the ID instruction actually reads rs / rt
//   id_regwrite      the ID instruction writes a register
//   id_dest          the ID instruction's destination register
//   id_is_load       the ID instruction is a load
//   flush            kill the instruction leaving ID (taken branch)
//   hold             freeze all tracked stages (memory wait)
//   cnt_clr          synchronous clear of stall_cnt
//   id_stall         ID/IF must not advance this cycle
//   mem_regwrite     MEM instruction writes a nonzero register
//   mem_write_reg    MEM destination register
//   wb_regwrite      WB instruction writes a nonzero register
//   wb_write_reg     WB destination register
//   ex_is_load_out   EX holds a valid load
//   stall_cnt        number of cycles in which id_stall was high (saturating)
// ---------------------------------------------------------------------------
module hazard_pipe_tracker #(
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic          id_regwrite,
    input  logic [AW-1:0] id_dest,
    input  logic          id_is_load,
    input  logic          flush,
    input  logic          hold,
    input  logic          cnt_clr,
    output logic          id_stall,
    output logic          mem_regwrite,
    output logic [AW-1:0] mem_write_reg,
    output logic          wb_regwrite,
    output logic [AW-1:0] wb_write_reg,
    output logic          ex_is_load_out,
    output logic [CW-1:0] stall_cnt
);

    localparam logic [CW-1:0] CntMax = '1;
    localparam logic [CW-1:0] CntOne = CW'(1);
    localparam logic [AW-1:0] RegZero = '0;

    // EX stage record
    logic          exVld;
    logic          exRegwrite;
    logic [AW-1:0] exDest;
    logic          exIsLoad;

    // MEM stage record
    logic          memVld;
    logic          memRegwrite;
    logic [AW-1:0] memDest;
    logic          memIsLoad;

    // WB stage record
    logic          wbVld;
    logic          wbRegwrite;
    logic [AW-1:0] wbDest;
    logic          wbIsLoad;

    logic          flushPend;
    logic [CW-1:0] stallCnt;

    logic          rsHit;
    logic          rtHit;
    logic          loadUse;
    logic          flushEff;
    logic          stallNow;

    // Hazard detection. A load in EX whose result is not available until the
    // end of MEM cannot be forwarded to an instruction entering EX next
    // cycle, so a dependent ID instruction waits one cycle. Register 0 is
    // never a real dependency. A load that does not write a register cannot
    // create one either. A flush (now or remembered from a hold) kills the
    // ID instruction anyway, so it overrides the stall.
    always_comb begin
        rsHit    = id_rs_used && (id_rs == exDest);
        rtHit    = id_rt_used && (id_rt == exDest);
        loadUse  = id_valid && exVld && exIsLoad && exRegwrite &&
                   (exDest != RegZero) && (rsHit || rtHit);
        flushEff = flush || flushPend;
        stallNow = hold || (loadUse && !flushEff);
    end

    // Stage advance. Hold freezes everything, but a flush that arrives
    // during a hold is remembered so the bubble is still inserted when the
    // pipeline restarts. Flush and load-use both put a bubble into EX while
    // the older instructions keep draining toward WB. Bubbles carry dest=0
    // so that they read as "no register" on the write_reg outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exVld       <= 1'b0;
            exRegwrite  <= 1'b0;
            exDest      <= '0;
            exIsLoad    <= 1'b0;
            memVld      <= 1'b0;
            memRegwrite <= 1'b0;
            memDest     <= '0;
            memIsLoad   <= 1'b0;
            wbVld       <= 1'b0;
            wbRegwrite  <= 1'b0;
            wbDest      <= '0;
            wbIsLoad    <= 1'b0;
            flushPend   <= 1'b0;
        end else if (hold) begin
            if (flush) begin
                flushPend <= 1'b1;
            end
        end else begin
            memVld      <= exVld;
            memRegwrite <= exRegwrite;
            memDest     <= exDest;
            memIsLoad   <= exIsLoad;
            wbVld       <= memVld;
            wbRegwrite  <= memRegwrite;
            wbDest      <= memDest;
            wbIsLoad    <= memIsLoad;
            if (flushEff || loadUse) begin
                exVld      <= 1'b0;
                exRegwrite <= 1'b0;
                exDest     <= '0;
                exIsLoad   <= 1'b0;
            end else begin
                exVld      <= id_valid;
                exRegwrite <= id_valid && id_regwrite;
                exDest     <= id_valid ? id_dest : RegZero;
                exIsLoad   <= id_valid && id_is_load;
            end
            if (flushEff) begin
                flushPend <= 1'b0;
            end
        end
    end

    // Stall-cycle counter. The clear wins over a stall in the same cycle.
    // The counter sticks at all-ones instead of wrapping, so a long memory
    // wait cannot make the count look small.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (cnt_clr) begin
            stallCnt <= '0;
        end else if (stallNow && (stallCnt != CntMax)) begin
            stallCnt <= stallCnt + CntOne;
        end
    end

    // Outputs come straight from the stage registers. The only value that
    // depends on the ID inputs is id_stall.
    assign id_stall       = stallNow;
    assign mem_regwrite   = memVld && memRegwrite && (memDest != RegZero);
    assign mem_write_reg  = memDest;
    assign wb_regwrite    = wbVld && wbRegwrite && (wbDest != RegZero);
    assign wb_write_reg   = wbDest;
    assign ex_is_load_out = exVld && exIsLoad;
    assign stall_cnt      = stallCnt;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_hazard_pipe_tracker
//
// Self-checking bench for hazard_pipe_tracker. A behavioural stage model
// predicts the post-edge outputs and pushes them into a scoreboard queue
// when stimulus is driven. The entry is popped and compared after the edge.
// Directed constant checks cover the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_hazard_pipe_tracker;

    logic        clk;
    logic        rst_n;
    logic        idValid;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic        idRsUsed;
    logic        idRtUsed;
    logic        idRegwrite;
    logic [4:0]  idDest;
    logic        idIsLoad;
    logic        flushIn;
    logic        holdIn;
    logic        cntClr;
    logic        idStall;
    logic        memRegwrite;
    logic [4:0]  memWriteReg;
    logic        wbRegwrite;
    logic [4:0]  wbWriteReg;
    logic        exIsLoadOut;
    logic [15:0] stallCnt;

    typedef struct packed {
        logic        memRw;
        logic [4:0]  memReg;
        logic        wbRw;
        logic [4:0]  wbReg;
        logic        exLd;
        logic [15:0] cnt;
    } expectT;

    expectT sbQueue[$];

    int vectorCount = 0;
    int missCount   = 0;

    // Model state: index 0 = EX, 1 = MEM, 2 = WB
    logic [2:0]  mVld;
    logic [2:0]  mRw;
    logic [2:0]  mLd;
    logic [4:0]  mDest [3];
    logic        mPend;
    logic [15:0] mCnt;
    logic        sampledStall;

    hazard_pipe_tracker #(.AW(5), .CW(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (idValid),
        .id_rs          (idRs),
        .id_rt          (idRt),
        .id_rs_used     (idRsUsed),
        .id_rt_used     (idRtUsed),
        .id_regwrite    (idRegwrite),
        .id_dest        (idDest),
        .id_is_load     (idIsLoad),
        .flush          (flushIn),
        .hold           (holdIn),
        .cnt_clr        (cntClr),
        .id_stall       (idStall),
        .mem_regwrite   (memRegwrite),
        .mem_write_reg  (memWriteReg),
        .wb_regwrite    (wbRegwrite),
        .wb_write_reg   (wbWriteReg),
        .ex_is_load_out (exIsLoadOut),
        .stall_cnt      (stallCnt)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        mVld  = '0;
        mRw   = '0;
        mLd   = '0;
        for (int i = 0; i < 3; i++) mDest[i] = '0;
        mPend = 1'b0;
        mCnt  = '0;
    endtask

    function automatic expectT modelOutputs();
        expectT e;
        e.memRw  = mVld[1] & mRw[1] & (mDest[1] != 5'd0);
        e.memReg = mDest[1];
        e.wbRw   = mVld[2] & mRw[2] & (mDest[2] != 5'd0);
        e.wbReg  = mDest[2];
        e.exLd   = mVld[0] & mLd[0];
        e.cnt    = mCnt;
        return e;
    endfunction

    task automatic compareAll(input string tag, input expectT e);
        checkOutput({tag, "_mem_rw"},  32'(memRegwrite), 32'(e.memRw));
        checkOutput({tag, "_mem_reg"}, 32'(memWriteReg), 32'(e.memReg));
        checkOutput({tag, "_wb_rw"},   32'(wbRegwrite),  32'(e.wbRw));
        checkOutput({tag, "_wb_reg"},  32'(wbWriteReg),  32'(e.wbReg));
        checkOutput({tag, "_ex_ld"},   32'(exIsLoadOut), 32'(e.exLd));
        checkOutput({tag, "_cnt"},     32'(stallCnt),    32'(e.cnt));
    endtask

    // Drive one cycle of stimulus (called with clk low), check id_stall
    // before the edge, step the model, then check the outputs after the edge.
    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic rsU, input logic rtU, input logic rw,
                                 input logic [4:0] dst, input logic ld,
                                 input logic fl, input logic hl, input logic clr);
        logic   lu;
        logic   fe;
        logic   expStall;
        expectT e;
        idValid = v;  idRs = rs;  idRt = rt;  idRsUsed = rsU;  idRtUsed = rtU;
        idRegwrite = rw;  idDest = dst;  idIsLoad = ld;
        flushIn = fl;  holdIn = hl;  cntClr = clr;
        #1;
        lu = v & mVld[0] & mLd[0] & mRw[0] & (mDest[0] != 5'd0) &
             ((rsU & (rs == mDest[0])) | (rtU & (rt == mDest[0])));
        fe = fl | mPend;
        expStall = hl | (lu & ~fe);
        sampledStall = idStall;
        checkOutput("id_stall", 32'(idStall), 32'(expStall));

        if (clr) mCnt = '0;
        else if (expStall && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;

        if (hl) begin
            if (fl) mPend = 1'b1;
        end else begin
            mVld[2] = mVld[1];  mRw[2] = mRw[1];  mLd[2] = mLd[1];  mDest[2] = mDest[1];
            mVld[1] = mVld[0];  mRw[1] = mRw[0];  mLd[1] = mLd[0];  mDest[1] = mDest[0];
            if (fe || lu) begin
                mVld[0] = 1'b0;  mRw[0] = 1'b0;  mLd[0] = 1'b0;  mDest[0] = 5'd0;
            end else begin
                mVld[0] = v;  mRw[0] = v & rw;  mLd[0] = v & ld;  mDest[0] = v ? dst : 5'd0;
            end
            if (fe) mPend = 1'b0;
        end
        sbQueue.push_back(modelOutputs());

        @(posedge clk);
        #1;
        if (sbQueue.size() == 0) begin
            checkOutput("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sbQueue.pop_front();
            compareAll("sb", e);
        end
        @(negedge clk);
    endtask

    task automatic nop();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic issueAdd(input logic [4:0] dst, input logic [4:0] rs, input logic rsU,
                            input logic [4:0] rt, input logic rtU, input logic fl);
        applyStimulus(1'b1, rs, rt, rsU, rtU, 1'b1, dst, 1'b0, fl, 1'b0, 1'b0);
    endtask

    task automatic issueLoad(input logic [4:0] dst, input logic rw);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, rw, dst, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        expectT zeroE;
        zeroE = '0;
        rst_n = 1'b0;
        idValid = 0; idRs = 0; idRt = 0; idRsUsed = 0; idRtUsed = 0;
        idRegwrite = 0; idDest = 0; idIsLoad = 0; flushIn = 0; holdIn = 0; cntClr = 0;
        resetModel();
        #2;
        compareAll("reset", zeroE);
        checkOutput("reset_stall", 32'(idStall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset then idle
        repeat (5) nop();
        checkOutput("idle_cnt", 32'(stallCnt), 32'd0);
        checkOutput("idle_mem_rw", 32'(memRegwrite), 32'd0);

        // Pass-through of ADD dest=5
        issueAdd(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        nop();
        checkOutput("pt_mem_rw", 32'(memRegwrite), 32'd1);
        checkOutput("pt_mem_reg", 32'(memWriteReg), 32'd5);
        nop();
        checkOutput("pt_wb_rw", 32'(wbRegwrite), 32'd1);
        checkOutput("pt_wb_reg", 32'(wbWriteReg), 32'd5);
        checkOutput("pt_mem_rw_off", 32'(memRegwrite), 32'd0);
        nop();
        checkOutput("pt_wb_rw_off", 32'(wbRegwrite), 32'd0);

        // Load-use on rs
        issueLoad(5'd3, 1'b1);
        checkOutput("lw_ex_ld", 32'(exIsLoadOut), 32'd1);
        issueAdd(5'd8, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        checkOutput("lu_rs_stall", 32'(sampledStall), 32'd1);
        checkOutput("lu_rs_cnt", 32'(stallCnt), 32'd1);
        checkOutput("lu_rs_bubble", 32'(exIsLoadOut), 32'd0);
        issueAdd(5'd8, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        checkOutput("lu_rs_once", 32'(sampledStall), 32'd0);
        checkOutput("lu_rs_lw_mem", 32'(memWriteReg), 32'd0);
        nop();
        checkOutput("lu_rs_add_mem", 32'(memWriteReg), 32'd8);
        nop();

        // Load-use on rt
        issueLoad(5'd3, 1'b1);
        issueAdd(5'd9, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        checkOutput("lu_rt_stall", 32'(sampledStall), 32'd1);
        issueAdd(5'd9, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        checkOutput("lu_rt_cnt", 32'(stallCnt), 32'd2);
        nop(); nop();

        // Destination 0 never stalls
        issueLoad(5'd0, 1'b1);
        issueAdd(5'd4, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        checkOutput("lu_zero_stall", 32'(sampledStall), 32'd0);
        // Load without regwrite never stalls
        issueLoad(5'd3, 1'b0);
        issueAdd(5'd4, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        checkOutput("lu_norw_stall", 32'(sampledStall), 32'd0);
        nop(); nop();

        // Flush beats load-use
        issueLoad(5'd3, 1'b1);
        issueAdd(5'd6, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1);
        checkOutput("fl_stall", 32'(sampledStall), 32'd0);
        checkOutput("fl_cnt", 32'(stallCnt), 32'd2);
        checkOutput("fl_lw_mem", 32'(memWriteReg), 32'd3);
        nop();
        checkOutput("fl_bubble_mem", 32'(memRegwrite), 32'd0);
        nop(); nop();

        // Hold with pending flush
        issueAdd(5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0,
                          (i == 1) ? 1'b1 : 1'b0, 1'b1, 1'b0);
            checkOutput("hold_stall", 32'(sampledStall), 32'd1);
        end
        checkOutput("hold_cnt", 32'(stallCnt), 32'd5);
        issueAdd(5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("hold_release_mem", 32'(memWriteReg), 32'd7);
        nop();
        checkOutput("hold_bubble_mem", 32'(memRegwrite), 32'd0);
        checkOutput("hold_wb_reg", 32'(wbWriteReg), 32'd7);
        nop(); nop();

        // Saturation: 2^16 + 2 held cycles
        holdIn = 1'b1;
        repeat (65538) @(posedge clk);
        @(negedge clk);
        mCnt = 16'hFFFF;
        checkOutput("sat_cnt", 32'(stallCnt), 32'h0000FFFF);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_cnt", 32'(stallCnt), 32'd0);

        // Asynchronous reset between edges
        issueAdd(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        nop();
        checkOutput("pre_rst_mem_rw", 32'(memRegwrite), 32'd1);
        checkOutput("pre_rst_cnt", 32'(stallCnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        resetModel();
        compareAll("async_rst", zeroE);
        @(negedge clk);
        rst_n = 1'b1;
        nop(); nop();
        checkOutput("post_rst_cnt", 32'(stallCnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
